// File: rtl/rf_pkg.sv
// Shared types and helpers for the multi-port register file.
// Optional read/write bypass is enabled by defining RF_BYPASS_EN.
package rf_pkg;

    typedef enum logic {RF_IDLE, RF_CLEAR} rf_state_e;

    function automatic int rf_aw(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/rf_clear_seq.sv
// Row-by-row clear sequencer: runs after reset or on clear_req,
// zeroing one row per cycle so the array itself needs no reset.
module rf_clear_seq
    import rf_pkg::*;
#(
    parameter int DEPTH = 256,
    localparam int AW = rf_aw(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear_req,
    output logic          busy,
    output logic          clr_we,
    output logic [AW-1:0] clr_addr
);

    rf_state_e     state_q;
    logic [AW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= RF_CLEAR;
            cnt_q   <= '0;
        end else begin
            unique case (state_q)
                RF_IDLE: begin
                    if (clear_req) begin
                        state_q <= RF_CLEAR;
                        cnt_q   <= '0;
                    end
                end
                RF_CLEAR: begin
                    // DEPTH is a power of two, so the counter wraps to 0 on exit
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == AW'(DEPTH - 1))
                        state_q <= RF_IDLE;
                end
                default: state_q <= RF_IDLE;
            endcase
        end
    end

    assign busy     = (state_q == RF_CLEAR);
    assign clr_we   = busy;
    assign clr_addr = cnt_q;

endmodule

// File: rtl/rf_multiport.sv
// Multi-port register file: NW write ports, NR registered read ports.
// Define RF_BYPASS_EN to forward same-edge write data to readers.
module rf_multiport
    import rf_pkg::*;
#(
    parameter int BW    = 8,
    parameter int DEPTH = 256,
    parameter int NR    = 2,
    parameter int NW    = 1,
    localparam int AW   = rf_aw(DEPTH)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        chip_en,
    input  logic                        clear_req,
    input  logic [NW-1:0]               write_en_n,
    input  logic [NW-1:0][AW-1:0]       write_addr,
    input  logic signed [NW-1:0][BW-1:0] data_in,
    input  logic [NR-1:0]               read_en,
    input  logic [NR-1:0][AW-1:0]       read_addr,
    output logic signed [NR-1:0][BW-1:0] data_out,
    output logic [NR-1:0]               rd_valid,
    output logic                        busy,
    output logic                        wr_drop
);

    logic signed [BW-1:0] mem [DEPTH];

    logic                 clr_we;
    logic [AW-1:0]        clr_addr;
    logic [NW-1:0]        wr_act;
    logic [NR-1:0][BW-1:0] rd_next;

    rf_clear_seq #(
        .DEPTH(DEPTH)
    ) u_clear_seq (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear_req(clear_req),
        .busy     (busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    always_comb begin
        for (int j = 0; j < NW; j++)
            wr_act[j] = chip_en && !write_en_n[j] && !busy;
    end

    // Loop order gives the highest-index port the final word
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr] <= '0;
        end else begin
            for (int j = 0; j < NW; j++)
                if (wr_act[j])
                    mem[write_addr[j]] <= data_in[j];
        end
    end

    always_comb begin
        for (int k = 0; k < NR; k++) begin
            rd_next[k] = mem[read_addr[k]];
`ifdef RF_BYPASS_EN
            for (int j = 0; j < NW; j++)
                if (wr_act[j] && write_addr[j] == read_addr[k])
                    rd_next[k] = data_in[j];
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_out <= '0;
            rd_valid <= '0;
            wr_drop  <= 1'b0;
        end else begin
            for (int k = 0; k < NR; k++) begin
                rd_valid[k] <= chip_en && read_en[k] && !busy;
                if (chip_en && read_en[k] && !busy)
                    data_out[k] <= rd_next[k];
            end
            wr_drop <= busy && chip_en && (~write_en_n != '0);
        end
    end

endmodule
